// File: rtl/cpu_pkg.sv
// Shared processor-side definitions: loader states and the widths that
// the boot loader, processor and instruction memory agree on.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int HDR_BYTES = 2;
  localparam int CSUM_W    = 8;
  localparam int WORD_W    = 16;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave; the host/bench side is the master.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  import cpu_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Pairs high/low stream bytes into words and drives the one-cycle
// instruction memory write along with the word index counter.
module loader_word_assembler
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hi_load,
  input  logic              lo_load,
  input  logic              clear,
  input  logic [7:0]        data,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] wdata,
  output logic [ADDR_W:0]   count
);

  logic [7:0] hi_byte;

  // The index advances on the edge that ends the write cycle, so the next
  // low byte (at least two edges later) always sees the updated count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_byte <= '0;
      we      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      count   <= '0;
    end else begin
      we <= lo_load;
      if (hi_load) hi_byte <= data;
      if (lo_load) begin
        wdata <= {hi_byte, data};
        addr  <= count[ADDR_W-1:0];
      end
      if (clear)   count <= '0;
      else if (we) count <= count + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction
// memory and keeps the processor in reset until a verified load completes.
module imem_boot_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_boot_loader_if.slave    bus,
  input  logic                 load_start,
  output logic                 cpu_reset,
  output logic                 load_done,
  output logic                 load_error,
  output logic [ADDR_W:0]      words_loaded
);

  localparam int HDR_W = HDR_BYTES * 8;

  loader_state_t     state, next_state;
  logic [7:0]        len_hi;
  logic [ADDR_W:0]   len_words;
  logic [CSUM_W-1:0] csum;
  logic [HDR_W-1:0]  hdr_len;
  logic [ADDR_W:0]   word_count;
  logic              ready, accept, hi_load, lo_load, restart, last_word;

  assign hdr_len   = {len_hi, bus.in_data};
  assign accept    = bus.in_valid && ready;
  assign last_word = (word_count + (ADDR_W+1)'(1)) == len_words;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_HDR_HI;
      len_hi    <= '0;
      len_words <= '0;
      csum      <= '0;
    end else begin
      state <= next_state;
      if (restart)                        csum <= '0;
      else if (accept && state != ST_CSUM) csum <= csum ^ bus.in_data;
      if (accept && state == ST_HDR_HI) len_hi    <= bus.in_data;
      if (accept && state == ST_HDR_LO) len_words <= hdr_len[ADDR_W:0];
    end
  end

  // Ready depends on state alone; transitions happen only on accepted bytes.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    hi_load    = 1'b0;
    lo_load    = 1'b0;
    restart    = 1'b0;
    case (state)
      ST_HDR_HI: begin
        ready = 1'b1;
        if (bus.in_valid) next_state = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          if (hdr_len > HDR_W'(MAX_WORDS)) next_state = ST_ERROR;
          else if (hdr_len == '0)          next_state = ST_CSUM;
          else                             next_state = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        ready   = 1'b1;
        hi_load = bus.in_valid;
        if (bus.in_valid) next_state = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        ready   = 1'b1;
        lo_load = bus.in_valid;
        if (bus.in_valid) next_state = last_word ? ST_CSUM : ST_DATA_HI;
      end
      ST_CSUM: begin
        ready = 1'b1;
        if (bus.in_valid) next_state = (bus.in_data == csum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (load_start) begin
          restart    = 1'b1;
          next_state = ST_HDR_HI;
        end
      end
      default: next_state = ST_HDR_HI;
    endcase
  end

  loader_word_assembler #(
    .ADDR_W (ADDR_W)
  ) u_asm (
    .clk     (clk),
    .reset   (reset),
    .hi_load (hi_load),
    .lo_load (lo_load),
    .clear   (restart),
    .data    (bus.in_data),
    .we      (bus.imem_we),
    .addr    (bus.imem_addr),
    .wdata   (bus.imem_wdata),
    .count   (word_count)
  );

  assign bus.in_ready  = ready;
  assign words_loaded  = word_count;
  assign cpu_reset     = (state != ST_DONE);
  assign load_done     = (state == ST_DONE);
  assign load_error    = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as
// stimulus is issued and a negedge monitor pops them on every imem_we.
module tb_imem_boot_loader;
  import cpu_pkg::*;

  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            load_start = 1'b0;
  logic            cpu_reset, load_done, load_error;
  logic [ADDR_W:0] words_loaded;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .load_start   (load_start),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write cycle must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check_output("write.addr", 32'(bus.imem_addr), 32'(e.addr));
        check_output("write.data", 32'(bus.imem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    @(negedge clk);
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      $display("[TB] FAIL send_timeout: got in_ready %b expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic apply_stimulus(input int max_gap);
    foreach (stim[i]) send_byte(stim[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic cpu_rst, input int words, input logic rdy);
    check_output({tag, ".load_done"},    32'(load_done),    32'(done));
    check_output({tag, ".load_error"},   32'(load_error),   32'(err));
    check_output({tag, ".cpu_reset"},    32'(cpu_reset),    32'(cpu_rst));
    check_output({tag, ".words_loaded"}, 32'(words_loaded), 32'(words));
    check_output({tag, ".in_ready"},     32'(bus.in_ready), 32'(rdy));
    check_output({tag, ".writes_left"},  32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".imem_we"},    32'(bus.imem_we),    32'd0);
    check_output({tag, ".imem_addr"},  32'(bus.imem_addr),  32'd0);
    check_output({tag, ".imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1, 0, 1'b1);
  endtask

  task automatic restart_load(input string tag);
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_status(tag, 1'b0, 1'b0, 1'b1, 0, 1'b1);
  endtask

  task automatic push_basic_writes();
    exp_q.push_back('{8'h00, 16'h1234});
    exp_q.push_back('{8'h01, 16'hABCD});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;

    // Basic two-word load, checksum 00^02^12^34^AB^CD = 42.
    push_basic_writes();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    apply_stimulus(0);
    check_status("basic", 1'b1, 1'b0, 1'b0, 2, 1'b0);

    // Wrong checksum: writes still land, processor stays in reset.
    restart_load("restart1");
    push_basic_writes();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    apply_stimulus(0);
    check_status("badsum", 1'b0, 1'b1, 1'b1, 2, 1'b0);
    restart_load("restart2");
    push_basic_writes();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    apply_stimulus(0);
    check_status("reload", 1'b1, 1'b0, 1'b0, 2, 1'b0);

    // Empty program.
    restart_load("restart3");
    stim = '{8'h00, 8'h00, 8'h00};
    apply_stimulus(0);
    check_status("empty", 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Length 257 exceeds capacity; no further bytes are taken.
    restart_load("restart4");
    stim = '{8'h01, 8'h01};
    apply_stimulus(0);
    check_status("overflow", 1'b0, 1'b1, 1'b1, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check_output("overflow.hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    check_status("overflow_hold", 1'b0, 1'b1, 1'b1, 0, 1'b0);

    // Random idle gaps between bytes.
    restart_load("restart5");
    push_basic_writes();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    apply_stimulus(5);
    check_status("gappy", 1'b1, 1'b0, 1'b0, 2, 1'b0);

    // Reset after the first data high byte, then a clean full load.
    restart_load("restart6");
    stim = '{8'h00, 8'h02, 8'h12};
    apply_stimulus(0);
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_basic_writes();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    apply_stimulus(0);
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 2, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
